// File: rtl/regfile_mp.sv
// regfile_mp: integer register file with two write ports and a load scoreboard.
//
// Write port A (i_wa_*) carries ALU/LUI/JAL results. Write port L (i_wl_*) carries
// load returns, which are byte/half/word extracted and sign or zero extended.
// Reads are combinational with write-first bypass (L over A over stored).
// A per-register pending bit marks destinations of outstanding loads.
// o_err is a sticky flag for protocol violations, and only reset clears it.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   i_rs1_addr/i_rs2_addr   read addresses
//   o_rs1_data/o_rs2_data   read data (combinational, bypassed)
//   o_rs1_pend/o_rs2_pend   operand still waiting on a load (combinational)
//   i_wa_en/addr/data       ALU write port
//   i_wl_en/addr/data       load write port (raw memory word, lane right-aligned)
//   i_wl_size/i_wl_unsigned load size (00 B, 01 H, 1x W) and extension mode
//   i_ld_issue/i_ld_rd      load issued, so mark i_ld_rd pending
//   o_pend_cnt              number of pending registers (registered)
//   o_err                   sticky protocol error (registered)
module regfile_mp #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned RESET_MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_rs1_pend,
  output logic            o_rs2_pend,
  input  logic            i_wa_en,
  input  logic [AW-1:0]   i_wa_addr,
  input  logic [XLEN-1:0] i_wa_data,
  input  logic            i_wl_en,
  input  logic [AW-1:0]   i_wl_addr,
  input  logic [XLEN-1:0] i_wl_data,
  input  logic [1:0]      i_wl_size,
  input  logic            i_wl_unsigned,
  input  logic            i_ld_issue,
  input  logic [AW-1:0]   i_ld_rd,
  output logic [AW:0]     o_pend_cnt,
  output logic            o_err
);

  localparam int unsigned NREGS = 2 ** AW;

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [AW:0]      r_pend_cnt;
  logic             r_err;

  logic [XLEN-1:0]  w_wl_ext;
  logic             w_wa_ok;
  logic             w_wl_ok;
  logic             w_collide;
  logic             w_err_set;
  logic [NREGS-1:0] w_pend_d;
  logic [AW:0]      w_cnt_d;

  // Load lane extraction and extension.
  always_comb begin
    w_wl_ext = i_wl_data;
    unique case (i_wl_size)
      2'b00:   w_wl_ext = {{(XLEN-8){~i_wl_unsigned & i_wl_data[7]}}, i_wl_data[7:0]};
      2'b01:   w_wl_ext = {{(XLEN-16){~i_wl_unsigned & i_wl_data[15]}}, i_wl_data[15:0]};
      default: w_wl_ext = i_wl_data;
    endcase
  end

  assign w_wa_ok   = i_wa_en && (i_wa_addr != '0);
  assign w_wl_ok   = i_wl_en && (i_wl_addr != '0);
  assign w_collide = w_wa_ok && w_wl_ok && (i_wa_addr == i_wl_addr);

  // Error sources: same-cycle dual write, ALU write over a pending load (WAW),
  // load issue to an already pending register, load return with nothing pending.
  assign w_err_set = w_collide
                   || (w_wa_ok && r_pend[i_wa_addr] && !w_collide)
                   || (i_ld_issue && (i_ld_rd != '0) && r_pend[i_ld_rd])
                   || (w_wl_ok && !r_pend[i_wl_addr]);

  // Scoreboard next state: a new issue wins over a same-cycle clear.
  always_comb begin
    w_pend_d = r_pend;
    if (i_wl_en) begin
      w_pend_d[i_wl_addr] = 1'b0;
    end
    if (i_ld_issue) begin
      w_pend_d[i_ld_rd] = 1'b1;
    end
    w_pend_d[0] = 1'b0;
  end

  always_comb begin
    w_cnt_d = '0;
    for (int i = 1; i < NREGS; i++) begin
      w_cnt_d = w_cnt_d + (AW+1)'(w_pend_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (RESET_MODE == 1) ? XLEN'(i) : '0;
      end
      r_pend     <= '0;
      r_pend_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      // Port L is written last so it wins an address collision.
      if (w_wa_ok) begin
        r_regs[i_wa_addr] <= i_wa_data;
      end
      if (w_wl_ok) begin
        r_regs[i_wl_addr] <= w_wl_ext;
      end
      r_pend     <= w_pend_d;
      r_pend_cnt <= w_cnt_d;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Write-first read bypass.
  always_comb begin
    o_rs1_data = r_regs[i_rs1_addr];
    if (i_rs1_addr == '0) begin
      o_rs1_data = '0;
    end else if (i_wl_en && (i_wl_addr == i_rs1_addr)) begin
      o_rs1_data = w_wl_ext;
    end else if (i_wa_en && (i_wa_addr == i_rs1_addr)) begin
      o_rs1_data = i_wa_data;
    end
  end

  always_comb begin
    o_rs2_data = r_regs[i_rs2_addr];
    if (i_rs2_addr == '0) begin
      o_rs2_data = '0;
    end else if (i_wl_en && (i_wl_addr == i_rs2_addr)) begin
      o_rs2_data = w_wl_ext;
    end else if (i_wa_en && (i_wa_addr == i_rs2_addr)) begin
      o_rs2_data = i_wa_data;
    end
  end

  // A same-cycle load return releases the operand.
  assign o_rs1_pend = r_pend[i_rs1_addr] && !(i_wl_en && (i_wl_addr == i_rs1_addr));
  assign o_rs2_pend = r_pend[i_rs2_addr] && !(i_wl_en && (i_wl_addr == i_rs2_addr));

  assign o_pend_cnt = r_pend_cnt;
  assign o_err      = r_err;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (RESET_MODE=1).
// Inputs change on the falling edge; combinational outputs are checked #1 later,
// and registered state is checked #1 after the following rising edge.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_pend, rs2_pend;
  logic        wa_en;
  logic [4:0]  wa_addr;
  logic [31:0] wa_data;
  logic        wl_en;
  logic [4:0]  wl_addr;
  logic [31:0] wl_data;
  logic [1:0]  wl_size;
  logic        wl_unsigned;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [5:0]  pend_cnt;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp #(.XLEN(32), .AW(5), .RESET_MODE(1)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .i_rs1_addr   (rs1_addr),
    .i_rs2_addr   (rs2_addr),
    .o_rs1_data   (rs1_data),
    .o_rs2_data   (rs2_data),
    .o_rs1_pend   (rs1_pend),
    .o_rs2_pend   (rs2_pend),
    .i_wa_en      (wa_en),
    .i_wa_addr    (wa_addr),
    .i_wa_data    (wa_data),
    .i_wl_en      (wl_en),
    .i_wl_addr    (wl_addr),
    .i_wl_data    (wl_data),
    .i_wl_size    (wl_size),
    .i_wl_unsigned(wl_unsigned),
    .i_ld_issue   (ld_issue),
    .i_ld_rd      (ld_rd),
    .o_pend_cnt   (pend_cnt),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drop all write/issue strobes at the falling edge.
  task automatic idle();
    @(negedge clk);
    reset    = 1'b0;
    wa_en    = 1'b0;
    wl_en    = 1'b0;
    ld_issue = 1'b0;
    #1;
  endtask

  // Let the current inputs commit, then land #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    idle();
  endtask

  // One load-return vector: issue to x7, then return with the given size/sign.
  task automatic load_vec(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] exp);
    idle();
    ld_issue = 1'b1; ld_rd = 5'd7;
    tick();
    idle();
    wl_en = 1'b1; wl_addr = 5'd7; wl_data = 32'h0000_80F0; wl_size = sz; wl_unsigned = uns;
    rs1_addr = 5'd7;
    #1;
    check({tag, "_byp"}, rs1_data, exp);
    tick();
    idle();
    check({tag, "_st"}, rs1_data, exp);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rs1_addr = '0; rs2_addr = '0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wl_en = 1'b0; wl_addr = '0; wl_data = '0; wl_size = 2'b10; wl_unsigned = 1'b0;
    ld_issue = 1'b0; ld_rd = '0;
    tick();
    tick();
    idle();

    // Reset state with debug reset values.
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    #1;
    check("rst_x5", rs1_data, 32'h0000_0005);
    check("rst_x0", rs2_data, 32'h0000_0000);
    check("rst_cnt", {26'b0, pend_cnt}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);

    // ALU write with same-cycle bypass.
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hDEAD_BEEF; rs1_addr = 5'd3;
    #1;
    check("wa_byp", rs1_data, 32'hDEAD_BEEF);
    tick();
    idle();
    check("wa_st", rs1_data, 32'hDEAD_BEEF);

    // Write to x0 is dropped.
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h1234_5678; rs1_addr = 5'd0;
    #1;
    check("x0_byp", rs1_data, 32'd0);
    tick();
    idle();
    check("x0_st", rs1_data, 32'd0);

    // Load extension vectors on 0x000080F0.
    load_vec("lb", 2'b00, 1'b0, 32'hFFFF_FFF0);
    load_vec("lbu", 2'b00, 1'b1, 32'h0000_00F0);
    load_vec("lh", 2'b01, 1'b0, 32'hFFFF_80F0);
    load_vec("lhu", 2'b01, 1'b1, 32'h0000_80F0);
    load_vec("lw", 2'b10, 1'b0, 32'h0000_80F0);
    load_vec("lrsv", 2'b11, 1'b0, 32'h0000_80F0);

    // Scoreboard set and same-cycle release.
    ld_issue = 1'b1; ld_rd = 5'd9;
    tick();
    idle();
    rs2_addr = 5'd9;
    #1;
    check("pend9", {31'b0, rs2_pend}, 32'd1);
    check("cnt1", {26'b0, pend_cnt}, 32'd1);
    wl_en = 1'b1; wl_addr = 5'd9; wl_data = 32'hCAFE_0009; wl_size = 2'b10;
    #1;
    check("rel9", {31'b0, rs2_pend}, 32'd0);
    check("rel9_data", rs2_data, 32'hCAFE_0009);
    tick();
    idle();
    check("cnt0", {26'b0, pend_cnt}, 32'd0);
    check("err_clean", {31'b0, err}, 32'd0);

    // Dual write to x4: load port wins, err sets and sticks.
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h11;
    wl_en = 1'b1; wl_addr = 5'd4; wl_data = 32'h22; wl_size = 2'b10;
    rs1_addr = 5'd4;
    #1;
    check("dual_byp", rs1_data, 32'h22);
    tick();
    idle();
    check("dual_st", rs1_data, 32'h22);
    check("dual_err", {31'b0, err}, 32'd1);
    tick();
    check("err_sticky", {31'b0, err}, 32'd1);

    // Double issue to x10.
    ld_issue = 1'b1; ld_rd = 5'd10;
    tick();
    idle();
    ld_issue = 1'b1; ld_rd = 5'd10;
    tick();
    idle();
    rs1_addr = 5'd10;
    #1;
    check("dbl_pend", {31'b0, rs1_pend}, 32'd1);
    check("dbl_cnt", {26'b0, pend_cnt}, 32'd1);
    check("dbl_err", {31'b0, err}, 32'd1);

    // Issue and return to pending x6 together: data lands, bit stays set.
    ld_issue = 1'b1; ld_rd = 5'd6;
    tick();
    idle();
    check("cnt2", {26'b0, pend_cnt}, 32'd2);
    ld_issue = 1'b1; ld_rd = 5'd6;
    wl_en = 1'b1; wl_addr = 5'd6; wl_data = 32'h66; wl_size = 2'b10;
    rs1_addr = 5'd6;
    #1;
    check("x6_rel", {31'b0, rs1_pend}, 32'd0);
    check("x6_byp", rs1_data, 32'h66);
    tick();
    idle();
    check("x6_st", rs1_data, 32'h66);
    check("x6_pend", {31'b0, rs1_pend}, 32'd1);
    check("x6_cnt", {26'b0, pend_cnt}, 32'd2);

    // Reset with loads outstanding; writes in the reset cycle are ignored.
    @(negedge clk);
    reset = 1'b1;
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h3333_3333;
    tick();
    idle();
    rs1_addr = 5'd6; rs2_addr = 5'd3;
    #1;
    check("r2_cnt", {26'b0, pend_cnt}, 32'd0);
    check("r2_err", {31'b0, err}, 32'd0);
    check("r2_x6", rs1_data, 32'h6);
    check("r2_x6p", {31'b0, rs1_pend}, 32'd0);
    check("r2_x3", rs2_data, 32'h3);

    // Stale return to x10 after reset: written, err set.
    wl_en = 1'b1; wl_addr = 5'd10; wl_data = 32'hA5A5_0010; wl_size = 2'b10;
    tick();
    idle();
    rs1_addr = 5'd10;
    #1;
    check("stale_data", rs1_data, 32'hA5A5_0010);
    check("stale_err", {31'b0, err}, 32'd1);

    // WAW: ALU write to a register awaiting a load.
    do_reset();
    ld_issue = 1'b1; ld_rd = 5'd11;
    tick();
    idle();
    check("waw_pre", {31'b0, err}, 32'd0);
    wa_en = 1'b1; wa_addr = 5'd11; wa_data = 32'hBEEF_0011;
    tick();
    idle();
    rs1_addr = 5'd11;
    #1;
    check("waw_data", rs1_data, 32'hBEEF_0011);
    check("waw_err", {31'b0, err}, 32'd1);
    check("waw_pend", {31'b0, rs1_pend}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core. It replaces the single-write-port file with two independent write ports: an ALU/LUI/JAL writeback and a load writeback with byte/half sign or zero extension. It adds write-first read bypass and a per-register load scoreboard that tells decode when an operand is still waiting on memory. It sits between decode (reads), the execute writeback and the data-memory return path.

## Interface
- XLEN, 32: register width in bits (≥16, multiple of 8).
- AW, 5: register address width; NREGS = 2**AW registers.
- RESET_MODE, 0: 0 = every register resets to 0; 1 = register i resets to i (debug); x0 is 0 in both modes.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- rs1_addr, rs2_addr  in  AW  read addresses.
- rs1_data, rs2_data  out  XLEN  read data, combinational.
- rs1_pend, rs2_pend  out  1  operand awaits an outstanding load, combinational.
- wa_en  in  1  ALU-port write enable.
- wa_addr  in  AW  ALU-port destination.
- wa_data  in  XLEN  ALU-port data.
- wl_en  in  1  load-port write enable.
- wl_addr  in  AW  load-port destination.
- wl_data  in  XLEN  raw memory word; the selected lane is right-aligned.
- wl_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- wl_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- ld_issue  in  1  load issued; mark ld_rd pending.
- ld_rd  in  AW  destination of the issued load.
- pend_cnt  out  AW+1  number of pending registers, registered.
- err  out  1  sticky protocol-error flag, registered.

## Operation
- Load extension: byte = wl_data[7:0], half = wl_data[15:0], each extended to XLEN per wl_unsigned. Word is passed through unchanged. The result is called wl_ext.
- Writes commit at posedge clk when the enable is high and the address is not 0.
- wa and wl hit the same non-zero address in the same cycle: wl_ext is stored and err is set.
- wa_en to a register whose pend bit is set, with no wl to that address in the same cycle: the write is performed and err is set (WAW hazard against a load).
- Reads return 0 for address 0. Otherwise the priority is: wl_ext if wl_en and wl_addr matches, else wa_data if wa_en and wa_addr matches, else the stored value. This is a write-first bypass.
- Scoreboard: pend[NREGS-1:1]; pend[0] is always 0.
  - ld_issue with ld_rd≠0 sets pend[ld_rd].
  - wl_en clears pend[wl_addr].
  - ld_issue and wl_en to the same address in the same cycle: the bit ends up set, because the new load wins.
  - ld_issue to a register that is already pending: err is set and the bit stays set.
  - wl_en to a non-pending register: err is set and the data is still written.
- rsN_pend = pend[rsN_addr] AND NOT (wl_en AND wl_addr == rsN_addr). A writeback in the same cycle releases the operand.
- pend_cnt is the popcount of pend after each edge.
- err is cleared only by reset.

## Timing
- Reads and rsN_pend: zero-cycle combinational path from the address and write-port inputs.
- Writes, pend, pend_cnt and err: update at the posedge where the inputs are sampled. The new state is visible on the stored path on the next cycle and on the bypass path in the same cycle.
- Reset at the posedge with reset=1:
  - All registers are set per RESET_MODE.
  - pend = 0, pend_cnt = 0, err = 0.
  - All writes, issues and error conditions in that cycle are ignored.
  - Reset in the middle of an outstanding load discards the pending state. A later wl to that register writes its data and sets err.
- Outputs during reset: rsN_data reflect the stored contents plus bypass; rsN_pend follow pend.

## Test plan
- Reset with RESET_MODE=1, then read x5 and x0 -> 0x00000005 and 0x00000000; pend_cnt=0, err=0.
- wa_en, wa_addr=3, wa_data=0xDEADBEEF, with rs1_addr=3 in the same cycle -> rs1_data=0xDEADBEEF combinationally and after the edge; a write to x0 is ignored and x0 still reads 0.
- wl_data=0x000080F0:
  - byte signed to x7 -> 0xFFFFFFF0
  - byte unsigned -> 0x000000F0
  - half signed -> 0xFFFF80F0
  - word -> 0x000080F0
- ld_issue ld_rd=9 -> next cycle rs2_addr=9 gives rs2_pend=1 and pend_cnt=1. wl_en wl_addr=9 gives rs2_pend=0 in the same cycle and pend_cnt=0 after the edge.
- wa and wl both to x4 in one cycle (0x11, 0x22 word) -> x4=0x22 and err=1 sticky. A second ld_issue to a pending x10 also leaves err=1 and pend[10]=1.
- ld_issue rd=6 and wl_en addr=6 in the same cycle, with x6 pending -> x6 updated, pend[6]=1 and pend_cnt unchanged. Reset asserted next cycle -> pend_cnt=0 and err=0.
